// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset vector, NOP encoding and the fetch FSM state type.
package cpu_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned INSTR_W   = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register. Flush loads a bubble, write-enable loads a valid instruction, otherwise it holds.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               we_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  pc4_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [ADDR_W-1:0]  pc4_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               valid_o
);

    logic [ADDR_W-1:0]  pc4_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc4_q   <= '0;
            instr_q <= INSTR_W'(NOP_INSTR);
            valid_q <= 1'b0;
        end else if (flush_i) begin
            pc4_q   <= '0;
            instr_q <= INSTR_W'(NOP_INSTR);
            valid_q <= 1'b0;
        end else if (we_i) begin
            pc4_q   <= pc4_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end
    end

    assign pc4_o   = pc4_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, fetch FSM with imem req/ready handshake, one-entry hold buffer, feeding IF/ID.
module fetch_stage #(
    parameter int unsigned        ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned        INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(cpu_pkg::RESET_PC)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ready_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [ADDR_W-1:0]  ifid_pc4_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic               ifid_valid_o,
    output logic [ADDR_W-1:0]  pc_o
);
    import cpu_pkg::*;

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] hold_q, hold_d;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  redirect_target;
    logic               ifid_we, ifid_flush;
    logic [INSTR_W-1:0] ifid_instr_d;

    assign pc_plus4        = pc_q + ADDR_W'(4);
    assign redirect_target = {redirect_pc_i[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    // Per-cycle priority in FETCH and HOLD: redirect > stall > ready.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        imem_req_o   = 1'b0;
        ifid_we      = 1'b0;
        ifid_flush   = 1'b0;
        ifid_instr_d = imem_rdata_i;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = FETCH;
            end
            FETCH: begin
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    pc_d       = redirect_target;
                    ifid_flush = 1'b1;
                end else if (stall_i) begin
                    if (imem_ready_i) begin
                        hold_d  = imem_rdata_i;
                        state_d = HOLD;
                    end
                end else if (imem_ready_i) begin
                    ifid_we = 1'b1;
                    pc_d    = pc_plus4;
                end else begin
                    ifid_flush = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    hold_d     = '0;
                    pc_d       = redirect_target;
                    ifid_flush = 1'b1;
                    state_d    = FETCH;
                end else if (!stall_i) begin
                    ifid_we      = 1'b1;
                    ifid_instr_d = hold_q;
                    pc_d         = pc_plus4;
                    state_d      = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;

    ifid_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_ifid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (ifid_we),
        .flush_i (ifid_flush),
        .pc4_i   (pc_plus4),
        .instr_i (ifid_instr_d),
        .pc4_o   (ifid_pc4_o),
        .instr_o (ifid_instr_o),
        .valid_o (ifid_valid_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset sequence, randomized run against a reference model.
module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, stall_i, redirect_i, imem_ready_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic [31:0] ifid_pc4_o, ifid_instr_o, pc_o;
    logic        ifid_valid_o;

    int checks = 0;
    int errors = 0;
    int fetch8 = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    assign imem_rdata_i = mem(imem_addr_o);

    fetch_stage #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rdata_i  (imem_rdata_i),
        .ifid_pc4_o    (ifid_pc4_o),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_valid_o  (ifid_valid_o),
        .pc_o          (pc_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_pc,
                           input logic [31:0] e_pc4, input logic [31:0] e_instr, input logic e_valid);
        chk({tag, " req"},   {31'b0, imem_req_o},   {31'b0, e_req});
        chk({tag, " addr"},  imem_addr_o,           e_pc);
        chk({tag, " pc"},    pc_o,                  e_pc);
        chk({tag, " pc4"},   ifid_pc4_o,            e_pc4);
        chk({tag, " instr"}, ifid_instr_o,          e_instr);
        chk({tag, " valid"}, {31'b0, ifid_valid_o}, {31'b0, e_valid});
    endtask

    typedef struct {
        logic        start, stall, redir;
        logic [31:0] rpc;
        logic        ready;
        logic        e_req;
        logic [31:0] e_pc, e_pc4, e_instr;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic sl, input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic e_req, input logic [31:0] e_pc,
                       input logic [31:0] e_pc4, input logic [31:0] e_instr, input logic e_valid);
        vec_t v;
        v.start = st; v.stall = sl; v.redir = rd; v.rpc = rpc; v.ready = rdy;
        v.e_req = e_req; v.e_pc = e_pc; v.e_pc4 = e_pc4; v.e_instr = e_instr; v.e_valid = e_valid;
        vecs.push_back(v);
    endtask

    // Reference model: "started" and "buffered" flags plus a plain PC and IF/ID tuple.
    bit          m_started, m_buffered;
    logic [31:0] m_pc, m_buf, m_pc4, m_instr;
    logic        m_valid;

    task automatic m_reset();
        m_started = 0; m_buffered = 0; m_pc = 0; m_buf = 0;
        m_pc4 = 0; m_instr = 0; m_valid = 0;
    endtask

    task automatic m_bubble();
        m_pc4 = 0; m_instr = 0; m_valid = 0;
    endtask

    task automatic m_deliver(input logic [31:0] instr);
        m_pc4 = m_pc + 32'd4; m_instr = instr; m_valid = 1; m_pc = m_pc + 32'd4;
    endtask

    task automatic m_step(input bit st, input bit sl, input bit rd, input logic [31:0] rpc, input bit rdy);
        if (!m_started) begin
            if (st) m_started = 1;
        end else if (rd) begin
            m_pc = rpc & ~32'h3; m_buffered = 0; m_bubble();
        end else if (m_buffered) begin
            if (!sl) begin m_deliver(m_buf); m_buffered = 0; end
        end else if (sl) begin
            if (rdy) begin m_buf = mem(m_pc); m_buffered = 1; end
        end else if (rdy) begin
            m_deliver(mem(m_pc));
        end else begin
            m_bubble();
        end
    endtask

    task automatic do_reset();
        rst_i = 0; start_i = 0; stall_i = 0; redirect_i = 0; redirect_pc_i = 0; imem_ready_i = 0;
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1;
    endtask

    initial begin
        // T1
        for (int i = 0; i < 5; i++) add(0,0,0,0,0, 0,0,0,0,0);
        add(1,0,0,0,0, 1,0,0,0,0);
        // T2
        add(1,0,0,0,1, 1,4,4,mem(0),1);
        add(1,0,0,0,1, 1,8,8,mem(4),1);
        // T3
        for (int i = 0; i < 3; i++) add(1,1,0,0,1, 0,8,8,mem(4),1);
        add(1,0,0,0,1, 1,12,12,mem(8),1);
        // T4
        add(1,0,0,0,1, 1,16,16,mem(12),1);
        add(1,0,0,0,0, 1,16,0,0,0);
        add(1,0,0,0,0, 1,16,0,0,0);
        add(1,0,0,0,1, 1,20,20,mem(16),1);
        // T5
        add(1,0,1,32'h40,1, 1,32'h40,0,0,0);
        add(1,0,0,0,1,      1,32'h44,32'h44,mem(32'h40),1);
        add(1,1,0,0,1,      0,32'h44,32'h44,mem(32'h40),1);
        add(1,1,1,32'h43,1, 1,32'h40,0,0,0);
        add(1,0,0,0,1,      1,32'h44,32'h44,mem(32'h40),1);
        add(1,1,1,32'h80,1, 1,32'h80,0,0,0);
        add(1,1,0,0,0,      1,32'h80,0,0,0);
        add(1,0,0,0,1,      1,32'h84,32'h84,mem(32'h80),1);
        add(1,1,0,0,0,      1,32'h84,32'h84,mem(32'h80),1);
        // T6
        add(1,0,1,32'hFFFF_FFFC,0, 1,32'hFFFF_FFFC,0,0,0);
        add(1,0,0,0,0,             1,32'hFFFF_FFFC,0,0,0);
        add(1,0,0,0,1,             1,0,0,mem(32'hFFFF_FFFC),1);
        add(1,1,0,0,1,             0,0,0,mem(32'hFFFF_FFFC),1);

        do_reset();
        chk_all("reset", 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            start_i = vecs[i].start; stall_i = vecs[i].stall; redirect_i = vecs[i].redir;
            redirect_pc_i = vecs[i].rpc; imem_ready_i = vecs[i].ready;
            #1;
            if (imem_req_o && imem_ready_i && imem_addr_o == 32'h8) fetch8++;
            @(posedge clk_i); #1;
            chk_all($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_pc,
                    vecs[i].e_pc4, vecs[i].e_instr, vecs[i].e_valid);
        end
        chk("fetch8 count", fetch8, 1);

        // Async reset dropped mid-cycle while in HOLD
        #2 rst_i = 0;
        #1 chk_all("async_rst", 0, 0, 0, 0, 0);
        @(posedge clk_i); #1;
        chk_all("rst_held", 0, 0, 0, 0, 0);
        start_i = 0; stall_i = 0; imem_ready_i = 1;
        #2 rst_i = 1;
        @(posedge clk_i); #1;
        chk_all("post_rst_idle", 0, 0, 0, 0, 0);
        start_i = 1;
        @(posedge clk_i); #1;
        chk_all("restart", 1, 0, 0, 0, 0);
        @(posedge clk_i); #1;
        chk_all("restart_fetch", 1, 4, 4, mem(0), 1);

        // Randomized run against the reference model
        do_reset();
        m_reset();
        for (int c = 0; c < 600; c++) begin
            logic        st, sl, rd, rdy;
            logic [31:0] rpc;
            st  = ($urandom_range(0, 3) == 0);
            sl  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : 32'($urandom);
            start_i = st; stall_i = sl; redirect_i = rd; redirect_pc_i = rpc; imem_ready_i = rdy;
            m_step(st, sl, rd, rpc, rdy);
            @(posedge clk_i); #1;
            chk_all($sformatf("rand%0d", c), m_started && !m_buffered, m_pc, m_pc4, m_instr, m_valid);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
